// File: rtl/serial_adder.sv
// Bit-serial adder: computes {cout,sum} = a + b + cin one bit per clock, LSB first,
// reusing the one-bit full_adder cell for every bit step.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic [WIDTH-1:0] r_sumShift;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CNT_W-1:0] r_count;

    logic w_accept;
    logic w_lastBit;
    logic w_s;
    logic w_cout;

    // A new request is only taken when no add is in flight, so captured operands stay intact.
    assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_lastBit = (r_state == SHIFT) && (r_count == CNT_W'(WIDTH - 1));

    full_adder u_fullAdder (r_opA[0], r_opB[0], r_carry, w_s, w_cout);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    w_nextState = start ? SHIFT : IDLE;
            SHIFT:   w_nextState = w_lastBit ? DONE : SHIFT;
            DONE:    w_nextState = start ? SHIFT : IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == SHIFT);
        done = (r_state == DONE);
    end

    // The counter holds at WIDTH-1 on the final step instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opA      <= '0;
            r_opB      <= '0;
            r_sumShift <= '0;
            r_carry    <= 1'b0;
            r_count    <= '0;
        end else if (w_accept) begin
            r_opA      <= a;
            r_opB      <= b;
            r_sumShift <= '0;
            r_carry    <= cin;
            r_count    <= '0;
        end else if (r_state == SHIFT) begin
            r_opA      <= {1'b0, r_opA[WIDTH-1:1]};
            r_opB      <= {1'b0, r_opB[WIDTH-1:1]};
            r_sumShift <= {w_s, r_sumShift[WIDTH-1:1]};
            r_carry    <= w_cout;
            if (!w_lastBit) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_lastBit) begin
            r_sum  <= {w_s, r_sumShift[WIDTH-1:1]};
            r_cout <= w_cout;
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: a cycle-count model of the add latency is
// compared with the DUT every cycle, and directed vectors pin literal results.

module tb_serial_adder;
    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;
    int donePulses = 0;

    // Model state: cycles remaining until the in-flight add completes (0 = not busy).
    int           remaining = 0;
    logic [W:0]   pending   = '0;
    logic [W:0]   expResult = '0;
    logic         expDone   = 1'b0;
    logic         modelOn   = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs only change on negedges, so 1 time unit after posedge they equal what the DUT sampled.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            remaining = 0;
            expDone   = 1'b0;
            expResult = '0;
            modelOn   = 1'b1;
        end else if (modelOn) begin
            expDone = 1'b0;
            if (remaining > 0) begin
                remaining = remaining - 1;
                if (remaining == 0) begin
                    expDone   = 1'b1;
                    expResult = pending;
                end
            end else if (start) begin
                pending   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                remaining = W;
            end
        end
        if (modelOn) begin
            checks++;
            if (busy !== (remaining > 0)) begin
                errors++;
                $display("[TB] FAIL busy @%0t got %b want %b", $time, busy, (remaining > 0));
            end
            checks++;
            if (done !== expDone) begin
                errors++;
                $display("[TB] FAIL done @%0t got %b want %b", $time, done, expDone);
            end
            checks++;
            if ({cout, sum} !== expResult) begin
                errors++;
                $display("[TB] FAIL result @%0t got %b want %b", $time, {cout, sum}, expResult);
            end
            if (done === 1'b1) donePulses++;
        end
    end

    // Issues one add starting at the current negedge and returns at the negedge of its done cycle;
    // inputs are scrambled while busy, including stray start requests.
    task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        start = 1'b1;
        a     = ta;
        b     = tb;
        cin   = tc;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            a     = W'($urandom);
            b     = W'($urandom);
            cin   = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic expBusy, input logic expDn,
                               input logic [W:0] want);
        checks++;
        if (busy !== expBusy || done !== expDn || {cout, sum} !== want) begin
            errors++;
            $display("[TB] FAIL %s got busy=%b done=%b {cout,sum}=%b want busy=%b done=%b {cout,sum}=%b",
                     name, busy, done, {cout, sum}, expBusy, expDn, want);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset", 1'b0, 1'b0, 5'b0_0000);
        rst = 1'b0;
        @(negedge clk);

        // Zero add: busy through the shift, done with zero result
        start = 1'b1; a = 4'b0000; b = 4'b0000; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checkOutput("zero_busy", 1'b1, 1'b0, 5'b0_0000);
        repeat (W) @(negedge clk);
        checkOutput("zero_done", 1'b0, 1'b1, 5'b0_0000);
        @(negedge clk);
        checkOutput("zero_idle", 1'b0, 1'b0, 5'b0_0000);

        applyStimulus(4'b1111, 4'b0001, 1'b0);
        checkOutput("f_plus_1", 1'b0, 1'b1, 5'b1_0000);

        // Back-to-back: second start issued in the done cycle
        applyStimulus(4'b1111, 4'b1111, 1'b1);
        checkOutput("f_plus_f_c", 1'b0, 1'b1, 5'b1_1111);
        applyStimulus(4'b0011, 4'b0101, 1'b0);
        checkOutput("b2b_3_plus_5", 1'b0, 1'b1, 5'b0_1000);
        @(negedge clk);
        checkOutput("hold_after_done", 1'b0, 1'b0, 5'b0_1000);

        // Start pulse with other operands mid-add must be ignored
        start = 1'b1; a = 4'b0001; b = 4'b0001; cin = 1'b0;
        @(negedge clk);
        start = 1'b0; a = 4'b0000; b = 4'b0000;
        @(negedge clk);
        start = 1'b1; a = 4'b0110; b = 4'b0110; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("ignore_mid_busy", 1'b1, 1'b0, 5'b0_1000);
        repeat (W - 2) @(negedge clk);
        checkOutput("ignore_done", 1'b0, 1'b1, 5'b0_0010);
        repeat (2) @(negedge clk);
        checkOutput("ignore_no_extra", 1'b0, 1'b0, 5'b0_0010);

        // Reset at the second edge after accept aborts with no done pulse
        start = 1'b1; a = 4'b0111; b = 4'b0111; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_abort", 1'b0, 1'b0, 5'b0_0000);
        repeat (W + 2) @(negedge clk);
        checkOutput("rst_no_done", 1'b0, 1'b0, 5'b0_0000);
        applyStimulus(4'b1010, 4'b0101, 1'b1);
        checkOutput("after_rst", 1'b0, 1'b1, 5'b1_0000);

        // Exhaustive back-to-back sweep
        donePulses = 0;
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            applyStimulus(v[3:0], v[7:4], v[8]);
            checkOutput("exhaustive", 1'b0, 1'b1,
                        {1'b0, v[3:0]} + {1'b0, v[7:4]} + {4'b0000, v[8]});
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (donePulses != 512) begin
            errors++;
            $display("[TB] FAIL done_pulse_count got %0d want 512", donePulses);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
